// File: rtl/imem_access_ctrl.sv
// rtl/imem_access_ctrl.sv - instruction store arbiter between boot loader and fetch pipeline
module imem_access_ctrl #(
  parameter int          ADDR_WORDS_LOG2 = 7,
  parameter logic [31:0] RESET_PC        = 32'd4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  output logic                       fetch_valid,
  output logic [31:0]                fetch_data,
  output logic                       cpu_hold,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  input  logic [31:0]                ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic [ADDR_WORDS_LOG2-1:0] mem_addr,
  output logic                       mem_we,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  output logic [7:0]                 load_count,
  output logic                       addr_err,
  output logic [31:0]                boot_pc
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t state, state_nxt;
  logic   ld_fire;
  logic   ld_ok;
  logic   fetch_ok;
  logic   fetch_serve;

  // A byte address is usable when word aligned and inside the store
  function automatic logic addr_in_store(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:ADDR_WORDS_LOG2+2] == '0);
  endfunction

  assign ld_ok    = addr_in_store(ld_addr);
  assign fetch_ok = addr_in_store(fetch_addr);
  assign boot_pc  = RESET_PC;

  // State register; reset always lands in BOOT so a torn burst must restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // Next state: loader activity in RUN parks the core; last word releases it
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT, HOLD: if (ld_fire && ld_last) state_nxt = RUN;
      RUN:        if (ld_valid)           state_nxt = HOLD;
      default:                            state_nxt = BOOT;
    endcase
  end

  // Outputs: the loader owns the store whenever the core is held
  always_comb begin
    cpu_hold    = (state != RUN) || ld_valid;
    ld_ready    = !reset && (state != RUN);
    ld_fire     = ld_valid && ld_ready;
    mem_we      = ld_fire && ld_ok;
    mem_wdata   = ld_data;
    mem_addr    = cpu_hold ? ld_addr[ADDR_WORDS_LOG2+1:2] : fetch_addr[ADDR_WORDS_LOG2+1:2];
    fetch_serve = (state == RUN) && !ld_valid && fetch_req;
  end

  // Fetch response register; bad addresses return a NOP instead of stale data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_data  <= 32'd0;
    end else begin
      fetch_valid <= fetch_serve;
      if (fetch_serve) fetch_data <= fetch_ok ? mem_rdata : 32'd0;
    end
  end

  // Write counter saturates so software can tell "many" from a wrapped small count
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               load_count <= 8'd0;
    else if (mem_we && load_count != 8'hFF)  load_count <= load_count + 8'd1;
  end

  // Sticky error for any rejected loader or fetch address
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                      addr_err <= 1'b0;
    else if ((fetch_serve && !fetch_ok) || (ld_fire && !ld_ok))     addr_err <= 1'b1;
  end

endmodule
